// File: rtl/ccip_csr_pkg.sv
// ============================================================================
//  Module      : ccip_csr_pkg
//  Description : CCI-P MMIO structures, CSR offsets, CTRL bits and length codes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ccip_csr_pkg;

    // MMIO request header as carried on c0 when mmioRdValid/mmioWrValid is set
    typedef struct packed {
        logic [15:0] address;
        logic [1:0]  length;
        logic        rsvd;
        logic [8:0]  tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef struct packed {
        t_ccip_c0_ReqMmioHdr hdr;
        logic [511:0]        data;
        logic                rspValid;
        logic                mmioRdValid;
        logic                mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        logic           c0TxAlmFull;
        logic           c1TxAlmFull;
        t_if_ccip_c0_Rx c0;
    } t_if_ccip_Rx;

    typedef struct packed {
        logic [8:0] tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        logic [63:0]         data;
    } t_if_ccip_c2_Tx;

    localparam logic [1:0]  c_LEN_4B       = 2'd0;
    localparam logic [1:0]  c_LEN_8B       = 2'd1;

    localparam logic [17:0] c_OFF_DFH      = 18'h00;
    localparam logic [17:0] c_OFF_AFU_ID_L = 18'h08;
    localparam logic [17:0] c_OFF_AFU_ID_H = 18'h10;
    localparam logic [17:0] c_OFF_RSVD0    = 18'h18;
    localparam logic [17:0] c_OFF_RSVD1    = 18'h20;
    localparam logic [17:0] c_OFF_SCRATCH  = 18'h28;
    localparam logic [17:0] c_OFF_CTRL     = 18'h30;
    localparam logic [17:0] c_OFF_BUF_ADDR = 18'h38;
    localparam logic [17:0] c_OFF_STATUS   = 18'h40;
    localparam logic [17:0] c_OFF_CYCLES   = 18'h48;

    localparam int          c_CTRL_START   = 0;
    localparam int          c_CTRL_CLEAR   = 1;

    localparam logic [63:0] c_DFH_DEFAULT  = 64'h1000_0000_0000_0000;

endpackage

`default_nettype wire

// File: rtl/ccip_mmio_csr.sv
// ============================================================================
//  Module      : ccip_mmio_csr
//  Description : AFU CSR block on CCI-P MMIO with a 2-stage read pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ccip_mmio_csr
    import ccip_csr_pkg::*;
#(
    parameter logic [63:0] AFU_ID_L  = 64'h0,
    parameter logic [63:0] AFU_ID_H  = 64'h0,
    parameter logic [63:0] DFH_VALUE = c_DFH_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    input  t_if_ccip_Rx    cp2af_sRxPort,
    output t_if_ccip_c2_Tx af2cp_c2Tx,
    output logic           csr_start,
    output logic           csr_clear,
    output logic [63:0]    csr_buf_addr,
    input  logic           sts_done,
    input  logic [63:0]    sts_cycles
);

    t_ccip_c0_ReqMmioHdr w_hdr;
    logic [17:0]         w_wrQwOff;
    logic                w_wr8B;
    logic                w_wrCtrl;
    logic [63:0]         w_wrData;
    logic                w_unused;

    logic                r_s1Valid;
    logic [8:0]          r_s1Tid;
    logic [14:0]         r_s1Qw;
    logic                r_s1Hi;
    logic [1:0]          r_s1Len;
    logic [63:0]         r_s1Cycles;
    logic                r_s1Done;

    logic [63:0]         r_scratch;
    logic [63:0]         r_bufAddr;
    logic                r_doneLatched;

    logic [17:0]         w_s1Off;
    logic [63:0]         w_rdWord;
    logic [63:0]         w_rdData;

    assign w_hdr     = cp2af_sRxPort.c0.hdr;
    assign w_wrQwOff = {w_hdr.address[15:1], 3'b000};
    assign w_wrData  = cp2af_sRxPort.c0.data[63:0];
    assign w_wr8B    = cp2af_sRxPort.c0.mmioWrValid && (w_hdr.length == c_LEN_8B);
    assign w_wrCtrl  = w_wr8B && (w_wrQwOff == c_OFF_CTRL);

    assign w_unused  = ^{cp2af_sRxPort.c0TxAlmFull, cp2af_sRxPort.c1TxAlmFull,
                         cp2af_sRxPort.c0.rspValid, w_hdr.rsvd,
                         cp2af_sRxPort.c0.data[511:64]};

    // Register mux runs off the stage-1 offset, so a write landing on the
    // same edge as stage 1 is already visible here.
    assign w_s1Off = {r_s1Qw, 3'b000};

    always_comb begin
        w_rdWord = 64'h0;
        case (w_s1Off)
            c_OFF_DFH:      w_rdWord = DFH_VALUE;
            c_OFF_AFU_ID_L: w_rdWord = AFU_ID_L;
            c_OFF_AFU_ID_H: w_rdWord = AFU_ID_H;
            c_OFF_SCRATCH:  w_rdWord = r_scratch;
            c_OFF_BUF_ADDR: w_rdWord = r_bufAddr;
            c_OFF_STATUS:   w_rdWord = {63'h0, r_s1Done};
            c_OFF_CYCLES:   w_rdWord = r_s1Cycles;
            default:        w_rdWord = 64'h0;
        endcase
    end

    always_comb begin
        w_rdData = w_rdWord;
        if (r_s1Len == c_LEN_4B) begin
            w_rdData = {32'h0, (r_s1Hi ? w_rdWord[63:32] : w_rdWord[31:0])};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1Valid     <= 1'b0;
            r_s1Tid       <= 9'h0;
            r_s1Qw        <= 15'h0;
            r_s1Hi        <= 1'b0;
            r_s1Len       <= 2'h0;
            r_s1Cycles    <= 64'h0;
            r_s1Done      <= 1'b0;
            af2cp_c2Tx    <= '0;
            csr_start     <= 1'b0;
            csr_clear     <= 1'b0;
            r_scratch     <= 64'h0;
            r_bufAddr     <= 64'h0;
            r_doneLatched <= 1'b0;
        end else begin
            r_s1Valid  <= cp2af_sRxPort.c0.mmioRdValid;
            r_s1Tid    <= w_hdr.tid;
            r_s1Qw     <= w_hdr.address[15:1];
            r_s1Hi     <= w_hdr.address[0];
            r_s1Len    <= w_hdr.length;
            r_s1Cycles <= sts_cycles;
            r_s1Done   <= r_doneLatched;

            af2cp_c2Tx <= '0;
            if (r_s1Valid) begin
                af2cp_c2Tx.hdr.tid     <= r_s1Tid;
                af2cp_c2Tx.mmioRdValid <= 1'b1;
                af2cp_c2Tx.data        <= w_rdData;
            end

            csr_start <= w_wrCtrl && w_wrData[c_CTRL_START];
            csr_clear <= w_wrCtrl && w_wrData[c_CTRL_CLEAR];

            if (w_wr8B && (w_wrQwOff == c_OFF_SCRATCH)) begin
                r_scratch <= w_wrData;
            end
            if (w_wr8B && (w_wrQwOff == c_OFF_BUF_ADDR)) begin
                r_bufAddr <= w_wrData;
            end

            // Clear acts on the accepting edge; a concurrent done wins.
            if (sts_done) begin
                r_doneLatched <= 1'b1;
            end else if (w_wrCtrl && w_wrData[c_CTRL_CLEAR]) begin
                r_doneLatched <= 1'b0;
            end
        end
    end

    assign csr_buf_addr = r_bufAddr;

endmodule

`default_nettype wire
